// File: rtl/reg_arb_pkg.sv
// Shared types and sizing helpers for the register-bus arbiter.
// Holds the FSM state encoding, the byte-enable width and the watchdog counter width.
package reg_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  // A disabled watchdog (0) still needs a 1-bit counter so the declarations stay legal.
  function automatic int wd_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Combinational round-robin picker: purely combinational, zero latency, no backpressure.
// The winner is the first eligible index searching upward (with wrap) from last_grant+1.
module reg_arb_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int idx;

  // Scanning from the farthest offset down lets the nearest eligible index overwrite the rest.
  always_comb begin
    winner    = '0;
    any_valid = |eligible;
    idx       = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (eligible[idx]) begin
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin share of one register bus: grant edge then >=1 BUSY cycle, rsp_ready combinational on completion.
// Requesters hold req_valid until rsp_ready; per-direction stalls only block arbitration, a watchdog ends hung accesses.
module reg_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_is_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wr_data,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wr_biten,
  output logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_rd_data,
  output logic                                rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id,
  output logic                                busy,
  output logic                                bus_req,
  output logic                                bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]               bus_addr,
  output logic [DATA_WIDTH-1:0]               bus_wr_data,
  output logic [DATA_WIDTH/8-1:0]             bus_wr_biten,
  input  logic [DATA_WIDTH-1:0]               bus_rd_data,
  input  logic                                bus_ready,
  input  logic                                bus_err,
  input  logic                                bus_req_stall_wr,
  input  logic                                bus_req_stall_rd
);

  import reg_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BEW   = be_width(DATA_WIDTH);
  localparam int WD_W  = wd_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       winner;
  logic                   any_elig;
  logic [NUM_REQ-1:0]     elig;
  logic                   cmd_is_wr;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_wr_data;
  logic [BEW-1:0]         cmd_wr_biten;
  logic [WD_W-1:0]        wd_cnt;
  logic                   in_busy;
  logic                   timeout;
  logic                   done;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] & ~(req_is_wr[i] ? bus_req_stall_wr : bus_req_stall_rd);
    end
  end

  reg_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible   (elig),
    .last_grant (last_grant),
    .winner     (winner),
    .any_valid  (any_elig)
  );

  assign in_busy = (state == ARB_BUSY);
  // wd_cnt holds (BUSY cycle number - 1), so WD_LAST marks the final allowed cycle.
  assign timeout = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
  assign done    = in_busy && (bus_ready || timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      grant_id     <= '0;
      cmd_is_wr    <= 1'b0;
      cmd_addr     <= '0;
      cmd_wr_data  <= '0;
      cmd_wr_biten <= '0;
      wd_cnt       <= '0;
    end else if (state == ARB_IDLE) begin
      if (any_elig) begin
        state        <= ARB_BUSY;
        grant_id     <= winner;
        cmd_is_wr    <= req_is_wr[winner];
        cmd_addr     <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_wr_data  <= req_wr_data[winner*DATA_WIDTH +: DATA_WIDTH];
        cmd_wr_biten <= req_wr_biten[winner*BEW +: BEW];
        wd_cnt       <= '0;
      end
    end else begin
      if (done) begin
        state      <= ARB_IDLE;
        last_grant <= grant_id;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign busy          = in_busy;
  assign bus_req       = in_busy;
  assign bus_req_is_wr = in_busy & cmd_is_wr;
  assign bus_addr      = in_busy ? cmd_addr : '0;
  assign bus_wr_data   = in_busy ? cmd_wr_data : '0;
  assign bus_wr_biten  = (in_busy && cmd_is_wr) ? cmd_wr_biten : '0;

  // A reset landing on the completing cycle abandons the access, so rst masks the response.
  always_comb begin
    rsp_ready   = '0;
    rsp_rd_data = '0;
    rsp_err     = 1'b0;
    if (done && !rst) begin
      rsp_ready[grant_id] = 1'b1;
      rsp_rd_data         = bus_ready ? bus_rd_data : '0;
      rsp_err             = bus_ready ? bus_err : 1'b1;
    end
  end

endmodule
